// File: rtl/sdram_arbiter.sv
// Request arbiter and auto-refresh scheduler in front of the sdram byte controller.
// Define SDRAM_ARB_RR_EN for round-robin video/CPU arbitration (default: video over CPU).
module sdram_arbiter #(
    parameter int unsigned REFRESH_CYCLES = 780
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        v_req,
    input  logic [22:0] v_addr,
    output logic        v_ack,
    output logic        v_valid,
    output logic [15:0] v_data,
    input  logic        c_req,
    input  logic        c_wr,
    input  logic [22:0] c_addr,
    input  logic [15:0] c_din,
    input  logic [1:0]  c_wdm,
    output logic        c_ack,
    output logic        c_valid,
    output logic [15:0] c_data,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        sd_refresh,
    output logic [22:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_wdm,
    input  logic [15:0] sd_dout,
    input  logic        sd_data_ready,
    input  logic        sd_busy,
    input  logic        sd_enabled
);

    localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] REF_LOAD = CW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic [1:0] {OWN_REF, OWN_VID, OWN_CPU} owner_t;

    state_t        state, state_nxt;
    owner_t        owner;
    logic          op_wr;
    logic [CW-1:0] ref_cnt;
    logic          ref_pending;
    logic          ref_expire, ref_due, can_grant;
    logic          grant_ref, grant_vid, grant_cpu;
    logic          rd_data, done_wr;

    // A refresh expiring this cycle already outranks a client request on the same edge.
    assign ref_expire = sd_enabled && (ref_cnt == '0);
    assign ref_due    = ref_pending || ref_expire;
    assign can_grant  = (state == IDLE) && sd_enabled && !sd_busy;
    assign grant_ref  = can_grant && ref_due;

`ifdef SDRAM_ARB_RR_EN
    logic last_cpu;

    assign grant_vid = can_grant && !ref_due && v_req && (!c_req || last_cpu);
    assign grant_cpu = can_grant && !ref_due && c_req && (!v_req || !last_cpu);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_cpu <= 1'b1;
        else if (grant_vid)
            last_cpu <= 1'b0;
        else if (grant_cpu)
            last_cpu <= 1'b1;
    end
`else
    assign grant_vid = can_grant && !ref_due && v_req;
    assign grant_cpu = can_grant && !ref_due && c_req && !v_req;
`endif

    assign rd_data = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && sd_data_ready
                     && !op_wr && (owner != OWN_REF);
    assign done_wr = (state == WAIT_DONE) && !sd_busy && (owner == OWN_CPU) && op_wr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_ref || grant_vid || grant_cpu) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (sd_busy) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!sd_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A grant that consumes this cycle's own expiry leaves nothing pending;
    // an expiry alongside a grant of an older pending refresh stays pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ref_cnt     <= REF_LOAD;
            ref_pending <= 1'b0;
        end else begin
            if (!sd_enabled || ref_cnt == '0)
                ref_cnt <= REF_LOAD;
            else
                ref_cnt <= ref_cnt - 1'b1;

            if (ref_expire && !(grant_ref && !ref_pending))
                ref_pending <= 1'b1;
            else if (grant_ref)
                ref_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner      <= OWN_REF;
            op_wr      <= 1'b0;
            sd_addr    <= '0;
            sd_din     <= '0;
            sd_wdm     <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_refresh <= 1'b0;
            v_ack      <= 1'b0;
            c_ack      <= 1'b0;
            v_valid    <= 1'b0;
            c_valid    <= 1'b0;
            v_data     <= '0;
            c_data     <= '0;
        end else begin
            sd_rd      <= grant_vid || (grant_cpu && !c_wr);
            sd_wr      <= grant_cpu && c_wr;
            sd_refresh <= grant_ref;
            v_ack      <= grant_vid;
            c_ack      <= grant_cpu;
            v_valid    <= rd_data && (owner == OWN_VID);
            c_valid    <= (rd_data && (owner == OWN_CPU)) || done_wr;

            if (grant_ref) begin
                owner <= OWN_REF;
                op_wr <= 1'b0;
            end else if (grant_vid) begin
                owner   <= OWN_VID;
                op_wr   <= 1'b0;
                sd_addr <= v_addr;
                sd_din  <= '0;
                sd_wdm  <= '0;
            end else if (grant_cpu) begin
                owner   <= OWN_CPU;
                op_wr   <= c_wr;
                sd_addr <= c_addr;
                sd_din  <= c_din;
                sd_wdm  <= c_wdm;
            end

            if (rd_data && owner == OWN_VID)
                v_data <= sd_dout;
            if (rd_data && owner == OWN_CPU)
                c_data <= sd_dout;
        end
    end

endmodule
